// File: rtl/pos_cache_pingpong.sv
// Per-cell particle position cache with ping-pong banks.
// The active bank serves force-pipeline reads while the shadow bank is
// refilled by the motion-update unit. Only particles whose destination cell
// matches this cell are stored. The banks swap atomically once the update
// window closes.
module pos_cache_pingpong #(
  parameter int DATA_WIDTH    = 32,
  parameter int PARTICLE_NUM  = 220,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_X        = 2,
  parameter int CELL_Y        = 2,
  parameter int CELL_Z        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       motion_update_enable,
  input  logic [ADDR_WIDTH-1:0]      in_read_address,
  input  logic                       in_rden,
  output logic [DATA_WIDTH-1:0]      out_particle_info,
  output logic                       out_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [3*CELL_ID_WIDTH-1:0] in_data_dst_cell,
  input  logic                       in_data_valid,
  output logic                       in_data_ready,
  output logic [ADDR_WIDTH-1:0]      out_particle_count,
  output logic                       out_overflow,
  output logic                       out_swap_done
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [3*CELL_ID_WIDTH-1:0] MY_CELL = {CELL_ID_WIDTH'(CELL_X),
                                                    CELL_ID_WIDTH'(CELL_Y),
                                                    CELL_ID_WIDTH'(CELL_Z)};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SWAP   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    bank_sel_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg [2];
  logic                    overflow_reg;
  logic                    swap_done_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg;
  logic                    rd_valid_reg;

  // Slot 0 of each bank is unused: address 0 reads back the count instead.
  logic [DATA_WIDTH-1:0]   mem [2][PARTICLE_NUM+1];

  logic                    shadow_sel;
  logic [ADDR_WIDTH-1:0]   shadow_cnt;
  logic [ADDR_WIDTH-1:0]   active_cnt;
  logic                    start_update;
  logic                    beat;
  logic                    match;
  logic                    wr_en;
  logic                    drop_full;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic                    rd_in_range;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign shadow_sel   = ~bank_sel_reg;
  assign shadow_cnt   = cnt_reg[shadow_sel];
  assign active_cnt   = cnt_reg[bank_sel_reg];
  assign start_update = (state_reg == IDLE) && motion_update_enable;

  assign in_data_ready = (state_reg == UPDATE);
  assign beat          = in_data_valid && in_data_ready;
  assign match         = (in_data_dst_cell == MY_CELL);
  assign wr_en         = beat && match && (shadow_cnt < MAX_CNT);
  assign drop_full     = beat && match && (shadow_cnt >= MAX_CNT);
  assign wr_idx        = shadow_cnt + 1'b1;

  // Out-of-range addresses are steered to slot 0 so the array index stays legal;
  // their data is discarded by the read mux anyway.
  assign rd_in_range = (in_read_address <= MAX_CNT);
  assign rd_idx      = rd_in_range ? in_read_address : '0;
  assign rd_word     = mem[bank_sel_reg][rd_idx];

  assign out_particle_count = active_cnt;
  assign out_overflow       = overflow_reg;
  assign out_swap_done      = swap_done_reg;
  assign out_particle_info  = rd_data_reg;
  assign out_valid          = rd_valid_reg;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic: the update window follows the enable level, then one swap cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (motion_update_enable)  state_next = UPDATE;
      UPDATE:  if (!motion_update_enable) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank select, per-bank counts, overflow flag and swap pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_sel_reg  <= 1'b0;
      cnt_reg[0]    <= '0;
      cnt_reg[1]    <= '0;
      overflow_reg  <= 1'b0;
      swap_done_reg <= 1'b0;
    end else begin
      swap_done_reg <= (state_reg == SWAP);
      if (state_reg == SWAP) bank_sel_reg <= ~bank_sel_reg;
      if (start_update) begin
        cnt_reg[shadow_sel] <= '0;
        overflow_reg        <= 1'b0;
      end else begin
        if (wr_en)     cnt_reg[shadow_sel] <= wr_idx;
        if (drop_full) overflow_reg        <= 1'b1;
      end
    end
  end

  // Shadow-bank write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[shadow_sel][wr_idx] <= in_data;
  end

  // Registered read: count at address 0, stored words within the active count, zero beyond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= in_rden;
      if (in_rden) begin
        if (in_read_address == '0)
          rd_data_reg <= DATA_WIDTH'(active_cnt);
        else if (rd_in_range && (in_read_address <= active_cnt))
          rd_data_reg <= rd_word;
        else
          rd_data_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pos_cache_pingpong.sv
// Self-checking bench for pos_cache_pingpong: reads are scoreboarded through
// an expected-value queue and compared when out_valid is due.
module tb_pos_cache_pingpong;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        motion_update_enable = 1'b0;
  logic [7:0]  in_read_address = '0;
  logic        in_rden = 1'b0;
  logic [31:0] out_particle_info;
  logic        out_valid;
  logic [31:0] in_data = '0;
  logic [11:0] in_data_dst_cell = '0;
  logic        in_data_valid = 1'b0;
  logic        in_data_ready;
  logic [7:0]  out_particle_count;
  logic        out_overflow;
  logic        out_swap_done;

  localparam logic [11:0] MATCH = 12'h222;
  localparam logic [11:0] OTHER = 12'h122;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  addr_q [$];
  logic        prev_rden;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [16];

  pos_cache_pingpong dut (
    .clk                  (clk),
    .rst                  (rst),
    .motion_update_enable (motion_update_enable),
    .in_read_address      (in_read_address),
    .in_rden              (in_rden),
    .out_particle_info    (out_particle_info),
    .out_valid            (out_valid),
    .in_data              (in_data),
    .in_data_dst_cell     (in_data_dst_cell),
    .in_data_valid        (in_data_valid),
    .in_data_ready        (in_data_ready),
    .out_particle_count   (out_particle_count),
    .out_overflow         (out_overflow),
    .out_swap_done        (out_swap_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Track the read strobe the DUT sampled so out_valid and data can be predicted.
  always @(posedge clk or negedge rst) begin
    if (!rst) prev_rden <= 1'b0;
    else      prev_rden <= in_rden;
  end

  // Scoreboard: compare out_valid every cycle and pop one expected word per read.
  always @(negedge clk) begin
    if (rst) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, prev_rden});
      if (prev_rden) begin
        if (exp_q.size() == 0) begin
          check("scoreboard underflow", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          logic [7:0]  a;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          $display("read addr %0d data %0h expected %0h", a, out_particle_info, e);
          check("read data", out_particle_info, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_rden       = 1'b0;
      in_data_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp);
    @(negedge clk);
    in_read_address = addr;
    in_rden         = 1'b1;
    in_data_valid   = 1'b0;
    exp_q.push_back(exp);
    addr_q.push_back(addr);
  endtask

  task automatic start_update();
    @(negedge clk);
    in_rden              = 1'b0;
    in_data_valid        = 1'b0;
    motion_update_enable = 1'b1;
  endtask

  // One write beat; with last set the enable drops in the same cycle.
  task automatic send_beat(input logic [31:0] data, input logic [11:0] dst, input bit last);
    @(negedge clk);
    check("ready during update", {31'b0, in_data_ready}, 32'd1);
    in_rden          = 1'b0;
    in_data          = data;
    in_data_dst_cell = dst;
    in_data_valid    = 1'b1;
    if (last) motion_update_enable = 1'b0;
  endtask

  task automatic wait_swap();
    int n;
    @(negedge clk);
    in_data_valid        = 1'b0;
    motion_update_enable = 1'b0;
    check("ready in swap", {31'b0, in_data_ready}, 32'd0);
    n = 0;
    while (!out_swap_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("swap_done seen", {31'b0, out_swap_done}, 32'd1);
    @(negedge clk);
    check("swap_done width", {31'b0, out_swap_done}, 32'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    check("reset info",     out_particle_info, 32'd0);
    check("reset valid",    {31'b0, out_valid}, 32'd0);
    check("reset ready",    {31'b0, in_data_ready}, 32'd0);
    check("reset count",    {24'b0, out_particle_count}, 32'd0);
    check("reset overflow", {31'b0, out_overflow}, 32'd0);
    check("reset swapdone", {31'b0, out_swap_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: reads on an empty cache.
    do_read(8'd0, 32'd0);
    do_read(8'd1, 32'd0);
    idle(1);
    do_read(8'd5, 32'd0);
    idle(2);

    // Test 2: 12 matching beats, the last one in the final update cycle.
    start_update();
    for (int i = 1; i <= 12; i++) send_beat(32'(i), MATCH, i == 12);
    wait_swap();
    check("count after t2", {24'b0, out_particle_count}, 32'd12);
    vecs[0] = '{8'd0, 32'd12};
    for (int i = 1; i <= 12; i++) vecs[i] = '{8'(i), 32'(i)};
    vecs[13] = '{8'd13, 32'd0};
    vecs[14] = '{8'd221, 32'd0};
    vecs[15] = '{8'd255, 32'd0};
    for (int i = 0; i < 16; i++) do_read(vecs[i].addr, vecs[i].exp);
    idle(2);

    // Test 3: alternating destinations, only matching beats stored.
    start_update();
    for (int i = 0; i < 10; i++) send_beat(32'(21 + i), (i % 2 == 0) ? MATCH : OTHER, i == 9);
    wait_swap();
    check("count after t3", {24'b0, out_particle_count}, 32'd5);
    do_read(8'd0, 32'd5);
    for (int i = 1; i <= 5; i++) do_read(8'(i), 32'(19 + 2 * i));
    do_read(8'd6, 32'd0);
    idle(2);

    // Test 4: continuous read of address 3 across an update and swap.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4 ready", {31'b0, in_data_ready}, (k >= 1 && k <= 5) ? 32'd1 : 32'd0);
      check("t4 count", {24'b0, out_particle_count}, (k <= 6) ? 32'd5 : 32'd4);
      check("t4 swap_done", {31'b0, out_swap_done}, (k == 7) ? 32'd1 : 32'd0);
      in_rden              = 1'b1;
      in_read_address      = 8'd3;
      exp_q.push_back((k <= 6) ? 32'd25 : 32'd102);
      addr_q.push_back(8'd3);
      motion_update_enable = (k <= 4);
      in_data_valid        = (k >= 1 && k <= 4);
      in_data              = 32'(99 + k);
      in_data_dst_cell     = MATCH;
    end
    idle(2);

    // Test 5: overflow with 221 matching beats.
    start_update();
    for (int i = 1; i <= 221; i++) send_beat(32'(1000 + i), MATCH, i == 221);
    wait_swap();
    check("count after t5", {24'b0, out_particle_count}, 32'd220);
    check("overflow after t5", {31'b0, out_overflow}, 32'd1);
    do_read(8'd0, 32'd220);
    do_read(8'd1, 32'd1001);
    do_read(8'd220, 32'd1220);
    do_read(8'd221, 32'd0);
    idle(2);
    check("overflow held", {31'b0, out_overflow}, 32'd1);

    // Test 6: reset in the middle of an update.
    start_update();
    for (int i = 1; i <= 4; i++) send_beat(32'(500 + i), MATCH, 1'b0);
    @(negedge clk);
    check("overflow cleared", {31'b0, out_overflow}, 32'd0);
    in_data_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6 count", {24'b0, out_particle_count}, 32'd0);
    check("t6 ready", {31'b0, in_data_ready}, 32'd0);
    check("t6 valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    motion_update_enable = 1'b0;
    @(negedge clk);
    check("t6 idle ready", {31'b0, in_data_ready}, 32'd0);
    do_read(8'd1, 32'd0);
    do_read(8'd0, 32'd0);
    idle(3);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
